// File: rtl/scroll_pkg.sv
// scroll_pkg: shared encodings for the scrolling frame-buffer address generator
// FSM states, scroll directions and bit positions inside the flip vector.
package scroll_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, PAUSED = 2'd2} state_t;
   typedef enum logic [2:0] {NONE = 3'd0, XINC = 3'd1, XDEC = 3'd2, YINC = 3'd3, YDEC = 3'd4} dir_t;
   localparam int FLIP_V = 0;
   localparam int FLIP_H = 1;
endpackage

// File: rtl/scroll_wrap_acc.sv
// scroll_wrap_acc: modular position accumulator, pos stays in [0, LIM-1]
// Ports: clk, rst (async, active high), en (tick), inc/dec (direction),
//        step (amount, < LIM), pos (current position).
module scroll_wrap_acc #(
   parameter int LIM = 320,
   parameter int W   = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         inc,
   input  logic         dec,
   input  logic [W-1:0] step,
   output logic [W-1:0] pos
);
   logic [W-1:0] d;
   // d = LIM - step; both wrap cases reduce to one compare against d or step.
   assign d = W'(LIM) - step;
   always_ff @(posedge clk or posedge rst)
      if (rst) pos <= '0;
      else if (en && inc) pos <= (pos >= d) ? pos - d : pos + step;
      else if (en && dec) pos <= (pos < step) ? pos + d : pos - step;
endmodule

// File: rtl/scroll_addr_gen.sv
// scroll_addr_gen: raster-to-frame-buffer address with 2-D wrapped scroll and mirroring
// Ports: clk, rst (async, active high); h_cnt/v_cnt raster position; frame_start
//        latches pending flips; left/right/up/down level requests; pause_tgl,
//        vflip_tgl, hflip_tgl one-cycle toggles; speed step multiplier;
//        pixel_addr registered RAM address; state FSM state; flip {hflip, vflip}.
module scroll_addr_gen
   import scroll_pkg::*;
#(
   parameter int IMG_W       = 320,
   parameter int IMG_H       = 240,
   parameter int ADDR_W      = 17,
   parameter int SCALE_SHIFT = 1,
   parameter int STEP        = 1,
   parameter int TICK_DIV    = 200000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [9:0]        h_cnt,
   input  logic [9:0]        v_cnt,
   input  logic              frame_start,
   input  logic              left,
   input  logic              right,
   input  logic              up,
   input  logic              down,
   input  logic              pause_tgl,
   input  logic              vflip_tgl,
   input  logic              hflip_tgl,
   input  logic [1:0]        speed,
   output logic [ADDR_W-1:0] pixel_addr,
   output logic [1:0]        state,
   output logic [1:0]        flip
);
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam int TW = $clog2(TICK_DIV);
   localparam logic [ADDR_W-1:0] W_L   = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] W_MAX = ADDR_W'(IMG_W - 1);
   localparam logic [ADDR_W-1:0] H_L   = ADDR_W'(IMG_H);
   localparam logic [ADDR_W-1:0] H_MAX = ADDR_W'(IMG_H - 1);

   logic [TW-1:0]     tcnt;
   logic              tick;
   state_t            st;
   dir_t              dir, pend_dir, req;
   logic [1:0]        pend_flip, tgl;
   logic [XW-1:0]     pos_x, sx;
   logic [YW-1:0]     pos_y, sy;
   logic [ADDR_W-1:0] hs, vs, hc, vc, xs, ys, ix, iy, ixf, iyf;

   assign tick  = tcnt == TW'(TICK_DIV - 1);
   assign sx    = XW'(STEP) << speed;
   assign sy    = YW'(STEP) << speed;
   assign state = st;
   assign tgl[FLIP_H] = hflip_tgl;
   assign tgl[FLIP_V] = vflip_tgl;

   // Fixed priority left > right > up > down, so only one axis ever moves.
   always_comb
      req = left ? XINC : right ? XDEC : up ? YINC : down ? YDEC : NONE;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         tcnt      <= '0;
         st        <= IDLE;
         dir       <= NONE;
         pend_dir  <= NONE;
         flip      <= 2'b00;
         pend_flip <= 2'b00;
      end else begin
         tcnt      <= tick ? '0 : tcnt + 1'b1;
         pend_flip <= pend_flip ^ tgl;
         // Flips only take effect at frame start to avoid tearing mid-frame.
         if (frame_start) flip <= pend_flip ^ tgl;
         case (st)
            IDLE:
               if (req != NONE) begin
                  st  <= MOVE;
                  dir <= req;
               end
            MOVE:
               if (pause_tgl) begin
                  st       <= PAUSED;
                  pend_dir <= (req != NONE) ? req : dir;
                  dir      <= NONE;
               end else if (req != NONE) dir <= req;
            PAUSED: begin
               if (req != NONE) pend_dir <= req;
               if (pause_tgl) begin
                  st  <= MOVE;
                  dir <= (req != NONE) ? req : pend_dir;
               end
            end
            default: st <= IDLE;
         endcase
      end

   scroll_wrap_acc #(.LIM(IMG_W), .W(XW)) u_acc_x (
      .clk (clk),
      .rst (rst),
      .en  (tick),
      .inc (dir == XINC),
      .dec (dir == XDEC),
      .step(sx),
      .pos (pos_x)
   );

   scroll_wrap_acc #(.LIM(IMG_H), .W(YW)) u_acc_y (
      .clk (clk),
      .rst (rst),
      .en  (tick),
      .inc (dir == YINC),
      .dec (dir == YDEC),
      .step(sy),
      .pos (pos_y)
   );

   // Counters are clamped to the image so blanking-area addresses stay in range.
   always_comb begin
      hs  = ADDR_W'(h_cnt >> SCALE_SHIFT);
      vs  = ADDR_W'(v_cnt >> SCALE_SHIFT);
      hc  = (hs > W_MAX) ? W_MAX : hs;
      vc  = (vs > H_MAX) ? H_MAX : vs;
      xs  = hc + ADDR_W'(pos_x);
      ys  = vc + ADDR_W'(pos_y);
      ix  = (xs >= W_L) ? xs - W_L : xs;
      iy  = (ys >= H_L) ? ys - H_L : ys;
      ixf = flip[FLIP_H] ? W_MAX - ix : ix;
      iyf = flip[FLIP_V] ? H_MAX - iy : iy;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) pixel_addr <= '0;
      else pixel_addr <= iyf * W_L + ixf;
endmodule

// File: tb/tb_scroll_addr_gen.sv
// tb_scroll_addr_gen: self-checking bench for scroll_addr_gen (TICK_DIV=4)
module tb_scroll_addr_gen;
   logic        clk = 0, rst = 0;
   logic [9:0]  h_cnt = 0, v_cnt = 0;
   logic        frame_start = 0, left = 0, right = 0, up = 0, down = 0;
   logic        pause_tgl = 0, vflip_tgl = 0, hflip_tgl = 0;
   logic [1:0]  speed = 0;
   logic [16:0] pixel_addr;
   logic [1:0]  state, flip;

   int nchk = 0, nerr = 0;
   int exp_q[$];
   int m_px, m_py, m_cnt, m_st, m_dir, m_pend;
   logic [1:0] m_flip, m_pflip;
   bit m_tick;

   typedef struct {int h; int v; int exp;} vec_t;
   vec_t tv[7];

   scroll_addr_gen #(.TICK_DIV(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .h_cnt      (h_cnt),
      .v_cnt      (v_cnt),
      .frame_start(frame_start),
      .left       (left),
      .right      (right),
      .up         (up),
      .down       (down),
      .pause_tgl  (pause_tgl),
      .vflip_tgl  (vflip_tgl),
      .hflip_tgl  (hflip_tgl),
      .speed      (speed),
      .pixel_addr (pixel_addr),
      .state      (state),
      .flip       (flip)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input int act, input int exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask

   function automatic int ref_addr(input int h, input int v, input int px, input int py, input logic [1:0] f);
      int hs, vs, ix, iy;
      hs = h / 2; if (hs > 319) hs = 319;
      vs = v / 2; if (vs > 239) vs = 239;
      ix = (hs + px) % 320;
      iy = (vs + py) % 240;
      if (f[1]) ix = 319 - ix;
      if (f[0]) iy = 239 - iy;
      return iy * 320 + ix;
   endfunction

   task automatic model_clear();
      m_px = 0; m_py = 0; m_cnt = 0; m_st = 0; m_dir = 0; m_pend = 0;
      m_flip = 0; m_pflip = 0; m_tick = 0;
      exp_q.delete();
   endtask

   task automatic step();
      int s, rq;
      exp_q.push_back(ref_addr(h_cnt, v_cnt, m_px, m_py, m_flip));
      @(posedge clk);
      s = 1 << speed;
      m_tick = (m_cnt == 3);
      m_cnt = m_tick ? 0 : m_cnt + 1;
      if (m_tick)
         case (m_dir)
            1: m_px = (m_px + s) % 320;
            2: m_px = (m_px - s + 320) % 320;
            3: m_py = (m_py + s) % 240;
            4: m_py = (m_py - s + 240) % 240;
            default: ;
         endcase
      rq = left ? 1 : right ? 2 : up ? 3 : down ? 4 : 0;
      case (m_st)
         0: if (rq != 0) begin m_st = 1; m_dir = rq; end
         1: if (pause_tgl) begin m_st = 2; m_pend = (rq != 0) ? rq : m_dir; m_dir = 0; end
            else if (rq != 0) m_dir = rq;
         default: begin
            if (rq != 0) m_pend = rq;
            if (pause_tgl) begin m_st = 1; m_dir = m_pend; end
         end
      endcase
      m_pflip = m_pflip ^ {hflip_tgl, vflip_tgl};
      if (frame_start) m_flip = m_pflip;
      #1;
      chk("sb_addr", int'(pixel_addr), exp_q.pop_front());
      chk("sb_state", int'(state), m_st);
      chk("sb_flip", int'(flip), int'(m_flip));
   endtask

   task automatic wait_tick();
      for (int i = 0; i < 8; i++) begin
         step();
         if (m_tick) break;
      end
   endtask

   task automatic do_reset();
      rst = 1;
      model_clear();
      #1;
      chk("rst_addr", int'(pixel_addr), 0);
      chk("rst_state", int'(state), 0);
      chk("rst_flip", int'(flip), 0);
      @(posedge clk);
      #1 rst = 0;
   endtask

   initial begin
      int fz_addr, fpx, fpy;
      tv[0] = '{10, 4, 645};
      tv[1] = '{0, 0, 0};
      tv[2] = '{639, 479, 76799};
      tv[3] = '{1, 1, 0};
      tv[4] = '{2, 2, 321};
      tv[5] = '{700, 600, 76799};
      tv[6] = '{100, 50, 8050};
      h_cnt = 10; v_cnt = 4;
      #1;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         h_cnt = 10'(tv[i].h); v_cnt = 10'(tv[i].v);
         step();
         chk("tbl_addr", int'(pixel_addr), tv[i].exp);
      end
      chk("idle_state", int'(state), 0);
      h_cnt = 0; v_cnt = 0;
      right = 1; step(); right = 0;
      wait_tick(); step();
      chk("wrap_down_x", int'(pixel_addr), 319);
      left = 1; step(); left = 0;
      wait_tick(); step();
      chk("wrap_up_x", int'(pixel_addr), 0);
      up = 1; step(); up = 0;
      repeat (3) wait_tick();
      step();
      chk("pos_y3", int'(pixel_addr), 960);
      speed = 3; down = 1; step(); down = 0;
      wait_tick(); step();
      chk("y_235", int'(pixel_addr), 75200);
      wait_tick(); step();
      chk("y_227", int'(pixel_addr), 72640);
      speed = 0; right = 1; step(); right = 0;
      pause_tgl = 1; step(); pause_tgl = 0;
      chk("paused", int'(state), 2);
      fpx = m_px; fpy = m_py;
      fz_addr = ref_addr(0, 0, fpx, fpy, 2'b00);
      right = 1; step(); right = 0;
      repeat (14) step();
      chk("frozen", int'(pixel_addr), fz_addr);
      pause_tgl = 1; step(); pause_tgl = 0;
      wait_tick(); step();
      chk("resume_dec", int'(pixel_addr), ref_addr(0, 0, (fpx + 319) % 320, fpy, 2'b00));
      pause_tgl = 1; left = 1; step(); pause_tgl = 0; left = 0;
      chk("pause_wins", int'(state), 2);
      fpx = m_px; fpy = m_py;
      pause_tgl = 1; step(); pause_tgl = 0;
      wait_tick(); step();
      chk("resume_inc", int'(pixel_addr), ref_addr(0, 0, (fpx + 1) % 320, fpy, 2'b00));
      do_reset();
      hflip_tgl = 1; step(); hflip_tgl = 0;
      repeat (3) step();
      chk("flip_held", int'(flip), 0);
      frame_start = 1; step(); frame_start = 0;
      chk("hflip_on", int'(flip), 2);
      step();
      chk("hflip_addr", int'(pixel_addr), 319);
      vflip_tgl = 1; frame_start = 1; step(); vflip_tgl = 0; frame_start = 0;
      chk("both_flip", int'(flip), 3);
      step();
      chk("both_addr", int'(pixel_addr), 76799);
      speed = 2; left = 1; step(); left = 0;
      repeat (25) wait_tick();
      step();
      chk("x100_addr", int'(pixel_addr), 76699);
      chk("x100_state", int'(state), 1);
      #3;
      do_reset();
      h_cnt = 10; v_cnt = 4; speed = 0;
      step();
      chk("post_rst", int'(pixel_addr), 645);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/scroll_addr_gen.md
Name: scroll_addr_gen

Overview:
Parametrised frame-buffer address generator for the VGA display path. It maps the raster position (h_cnt, v_cnt) onto a scaled source image held in block RAM, adding a 2-D scroll offset with wrap-around and independent horizontal/vertical mirroring. Scrolling is driven by keyboard-derived direction and toggle pulses through a small state machine. Everything runs on the single pixel clock; scroll steps are paced by an internal tick divider, replacing any divided slow clock.

Parameters:
IMG_W, 320, source image width in pixels
IMG_H, 240, source image height in pixels
ADDR_W, 17, pixel_addr width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
SCALE_SHIFT, 1, raster-to-image downscale: image coordinate = cnt >> SCALE_SHIFT
STEP, 1, base scroll step in pixels per tick
TICK_DIV, 200000, pixel-clock cycles per scroll tick (>= 2)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
h_cnt  in  10  raster column, 0..639 in the active area
v_cnt  in  10  raster row, 0..479 in the active area
frame_start  in  1  one-cycle pulse at the start of vertical blanking
left, right, up, down  in  1 each  direction requests, level-sensitive
pause_tgl  in  1  one-cycle pulse; toggles run/pause
vflip_tgl, hflip_tgl  in  1 each  one-cycle pulses; toggle mirroring
speed  in  2  step multiplier select: effective step = STEP << speed
pixel_addr  out  ADDR_W  registered RAM read address
state  out  2  current FSM state, for debug LEDs
flip  out  2  {hflip, vflip} currently applied

Behaviour:
- Reset (async): pos_x=0, pos_y=0, dir=NONE, pend_dir=NONE, state=IDLE, flip=00, pending flip=00, tick counter=0, pixel_addr=0.
- Tick: the counter counts 0..TICK_DIV-1, and tick=1 for one cycle when it wraps. Position changes only on tick.
- Direction priority when several are asserted in the same cycle: left > right > up > down. Only one axis moves at a time.
- Direction encoding: left => pos_x increases; right => pos_x decreases; up => pos_y increases; down => pos_y decreases.
- FSM states: IDLE=0, MOVE=1, PAUSED=2.
  - IDLE: any direction request -> MOVE with dir set; pause_tgl is ignored.
  - MOVE: a direction request updates dir. pause_tgl -> PAUSED, with dir copied to pend_dir and dir=NONE. If pause_tgl and a direction arrive together, pause wins and the direction goes to pend_dir.
  - PAUSED: direction requests update pend_dir only; the position is frozen. pause_tgl -> MOVE with dir=pend_dir.
- Wrap arithmetic: s = STEP << speed, with s < min(IMG_W, IMG_H) required.
  - Increment: pos+s >= LIM ? pos+s-LIM : pos+s.
  - Decrement: pos < s ? pos+LIM-s : pos-s.
  - LIM is IMG_W for x and IMG_H for y. The position is always in [0, LIM-1].
- Flip: a toggle pulse inverts the pending flip bit in any state, including IDLE. Pending bits are copied to flip on frame_start, so there is no mid-frame tear. A toggle and frame_start in the same cycle are both applied: the toggled value is what gets copied.
- Address:
  - ix = (h_cnt >> SCALE_SHIFT) + pos_x, reduced once mod IMG_W. One subtract is sufficient because both terms are < IMG_W in the active area.
  - iy is computed the same way from v_cnt, pos_y and IMG_H.
  - hflip: ix' = IMG_W-1-ix. vflip: iy' = IMG_H-1-iy.
  - pixel_addr = iy'*IMG_W + ix', registered. Latency is 1 clk from h_cnt/v_cnt. The value is always < IMG_W*IMG_H.
- Outside the active area the address is still computed from the clamped counters; the display path blanks the pixel.
- Reset mid-frame or mid-tick returns immediately to the reset values. The tick phase restarts.

Decomposition:
- Shared package scroll_pkg holds:
  - state encoding: IDLE, MOVE, PAUSED
  - direction encoding: NONE, XINC, XDEC, YINC, YDEC
  - flip bit indices
- Sub-module scroll_wrap_acc (parameter LIM, width): modular position accumulator with inc/dec/step inputs. Instantiated once for x and once for y.

Test Plan:
1. Release reset with h_cnt=10, v_cnt=4 and idle inputs -> pixel_addr=2*320+5=645 one clk later; state=IDLE.
2. left held, TICK_DIV=4, speed=0 -> pos_x advances 1 every 4 clks. From pos_x=319 the next tick gives 0. With h_cnt=0, v_cnt=0 the address reads 0 after the wrap.
3. speed=3 (s=8), down from pos_y=3 -> pos_y=235, then 227 on the next tick.
4. In MOVE, issue pause_tgl, then right while PAUSED, then pause_tgl -> position frozen for >= 3 ticks, after which pos_x decreases. Pause+left in the same cycle -> PAUSED with pend_dir=XINC.
5. hflip_tgl mid-frame -> flip unchanged until frame_start, then flip=10. At h_cnt=0, v_cnt=0, pos=0 -> pixel_addr=319. Both flips -> 76799.
6. Assert rst during MOVE with pos_x=100 -> all outputs return to reset values asynchronously, before the next clk edge.
